// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Decides each cycle whether the instruction in ID must be held. The
//   result, stall, drives the ID-stage bubble mux and gates the PC and
//   IF/ID write enables.
//
//   Two sources of stall:
//     * load-use: a load in EX writes a register that ID reads. This is
//       combinational and takes effect in the same cycle.
//     * multi-cycle FP (fdiv/fsqrt): once the op enters EX, ID is held for
//       exactly MC_LAT cycles. That is the start cycle plus MC_LAT-1 BUSY
//       cycles.
//   A saturating counter tracks stall cycles for profiling.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   id_rs{1,2,3}[4:0]              ID source register indices
//   id_use_rs{1,2,3}               ID instruction reads rsN
//   id_rs{1,2,3}_fp                rsN is an FP register
//   ex_rd[4:0], ex_rd_fp           EX destination index / FP flag
//   ex_mem_read, ex_reg_write      EX is a load / writes rd
//   ex_mc_start                    multi-cycle FP op entered EX (pulse)
//   flush                          ID instruction is being squashed
//   stall, pc_write, if_id_write   hold / enables
//   mc_busy, mc_done, mc_overrun   multi-cycle FSM status
//   perf_stall_cnt[PERF_W-1:0]     saturating stall-cycle count
module hazard_stall_unit #(
  parameter int MC_LAT = 8,
  parameter int CNT_W  = 5,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rs3,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_use_rs3,
  input  logic              id_rs1_fp,
  input  logic              id_rs2_fp,
  input  logic              id_rs3_fp,
  input  logic [4:0]        ex_rd,
  input  logic              ex_rd_fp,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic              ex_mc_start,
  input  logic              flush,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              mc_overrun,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  localparam int NSRC = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

  // ---------------- load-use detection ----------------
  logic [NSRC-1:0][4:0] w_rs;
  logic [NSRC-1:0]      w_use;
  logic [NSRC-1:0]      w_fp;
  logic [NSRC-1:0]      w_match;
  logic                 w_load_use;

  assign w_rs  = {id_rs3, id_rs2, id_rs1};
  assign w_use = {id_use_rs3, id_use_rs2, id_use_rs1};
  assign w_fp  = {id_rs3_fp, id_rs2_fp, id_rs1_fp};

  // Integer x0 is hardwired to zero and can never carry a hazard.
  // FP f0 is an ordinary register, so an FP source at index 0 still matches.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign w_match[g] = w_use[g] && (w_rs[g] == ex_rd) && (w_fp[g] == ex_rd_fp)
                        && (w_fp[g] || (w_rs[g] != 5'd0));
  end

  assign w_load_use = ex_mem_read && ex_reg_write && (|w_match);

  // ---------------- multi-cycle FP sequencer ----------------
  mc_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_mc_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    unique case (r_state)
      IDLE: if (ex_mc_start) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_W'(MC_LAT - 1);
        w_mc_stall  = 1'b1;
      end
      BUSY: begin
        w_mc_stall = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
        else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // flush squashes only the ID instruction. An op already in EX is older
  // than the branch, so flush never affects the FSM.
  assign stall       = (w_load_use && !flush) || w_mc_stall;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign mc_busy     = (r_state == BUSY);
  assign mc_done     = (r_state == DONE);

  // ---------------- overrun flag + profiling ----------------
  logic              r_overrun;
  logic [PERF_W-1:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_perf    <= '0;
    end else begin
      if (ex_mc_start && (r_state != IDLE)) r_overrun <= 1'b1;
      if (stall && (r_perf != {PERF_W{1'b1}})) r_perf <= r_perf + PERF_W'(1);
    end
  end

  assign mc_overrun     = r_overrun;
  assign perf_stall_cnt = r_perf;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, id_rs3, ex_rd;
  logic id_use_rs1, id_use_rs2, id_use_rs3;
  logic id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic ex_rd_fp, ex_mem_read, ex_reg_write, ex_mc_start, flush;

  logic stall, pc_write, if_id_write, mc_busy, mc_done, mc_overrun;
  logic [15:0] perf_stall_cnt;
  logic s_stall, s_pc_write, s_if_id_write, s_mc_busy, s_mc_done, s_mc_overrun;
  logic [3:0] s_perf;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MC_LAT(8), .CNT_W(5), .PERF_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_rs3(id_use_rs3),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp), .id_rs3_fp(id_rs3_fp),
    .ex_rd(ex_rd), .ex_rd_fp(ex_rd_fp), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_mc_start(ex_mc_start), .flush(flush),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_overrun(mc_overrun),
    .perf_stall_cnt(perf_stall_cnt));

  // Narrow profiling counter, used for the saturation check.
  hazard_stall_unit #(.MC_LAT(8), .CNT_W(5), .PERF_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_rs3(id_use_rs3),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp), .id_rs3_fp(id_rs3_fp),
    .ex_rd(ex_rd), .ex_rd_fp(ex_rd_fp), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_mc_start(ex_mc_start), .flush(flush),
    .stall(s_stall), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .mc_busy(s_mc_busy), .mc_done(s_mc_done), .mc_overrun(s_mc_overrun),
    .perf_stall_cnt(s_perf));

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rs3;
    logic       u1, u2, u3, f1, f2, f3;
    logic [4:0] rd;
    logic       rdf, mr, rw, fl;
    logic       exp_stall;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_perf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_rs3 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_use_rs3 = 0;
    id_rs1_fp = 0; id_rs2_fp = 0; id_rs3_fp = 0;
    ex_rd_fp = 0; ex_mem_read = 0; ex_reg_write = 0; ex_mc_start = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs3 = v.rs3;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_use_rs3 = v.u3;
    id_rs1_fp = v.f1; id_rs2_fp = v.f2; id_rs3_fp = v.f3;
    ex_rd = v.rd; ex_rd_fp = v.rdf; ex_mem_read = v.mr; ex_reg_write = v.rw;
    flush = v.fl; ex_mc_start = 0;
  endtask

  function automatic vec_t mk(input string n,
                              input logic [4:0] rs1, rs2, rs3,
                              input logic [2:0] use_, fp_,
                              input logic [4:0] rd, input logic rdf, mr, rw, fl, es);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    {v.u3, v.u2, v.u1} = use_;
    {v.f3, v.f2, v.f1} = fp_;
    v.rd = rd; v.rdf = rdf; v.mr = mr; v.rw = rw; v.fl = fl; v.exp_stall = es;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // use/fp bit order is {rs3, rs2, rs1}
    vecs.push_back(mk("int_rs2_match",   0, 5, 0, 3'b010, 3'b000, 5, 0, 1, 1, 0, 1));
    vecs.push_back(mk("int_x0_nomatch",  0, 0, 0, 3'b010, 3'b000, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("fp_vs_int",       0, 5, 0, 3'b010, 3'b010, 5, 0, 1, 1, 0, 0));
    vecs.push_back(mk("fp_f0_match",     0, 0, 0, 3'b010, 3'b010, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk("rs2_unused",      0, 5, 0, 3'b000, 3'b000, 5, 0, 1, 1, 0, 0));
    vecs.push_back(mk("int_rs1_match",   9, 3, 0, 3'b011, 3'b000, 9, 0, 1, 1, 0, 1));
    vecs.push_back(mk("fp_rs3_fma",      1, 2, 7, 3'b111, 3'b111, 7, 1, 1, 1, 0, 1));
    vecs.push_back(mk("rs3_unused",      1, 2, 7, 3'b011, 3'b111, 7, 1, 1, 1, 0, 0));
    vecs.push_back(mk("no_reg_write",    0, 5, 0, 3'b010, 3'b000, 5, 0, 1, 0, 0, 0));
    vecs.push_back(mk("not_load",        0, 5, 0, 3'b010, 3'b000, 5, 0, 0, 1, 0, 0));
    vecs.push_back(mk("index_mismatch",  4, 6, 0, 3'b011, 3'b000, 5, 0, 1, 1, 0, 0));
    vecs.push_back(mk("flush_masks",     0, 5, 0, 3'b010, 3'b000, 5, 0, 1, 1, 1, 0));
    vecs.push_back(mk("int_rs2_again",   0, 31, 0, 3'b010, 3'b000, 31, 0, 1, 1, 0, 1));

    // ---- reset state ----
    clr();
    rst_n = 1'b0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_if_id_write", if_id_write, 1);
    chk("rst_mc_busy", mc_busy, 0);
    chk("rst_mc_done", mc_done, 0);
    chk("rst_overrun", mc_overrun, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_stall", stall, 0);
    chk("post_rst_perf", perf_stall_cnt, 0);

    // ---- load-use table ----
    exp_perf = 0;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_stall"}, stall, vecs[i].exp_stall);
      chk({vecs[i].name, "_pc_write"}, pc_write, !vecs[i].exp_stall);
      chk({vecs[i].name, "_if_id_write"}, if_id_write, !vecs[i].exp_stall);
      tick();
      exp_perf += int'(vecs[i].exp_stall);
      chk({vecs[i].name, "_perf"}, perf_stall_cnt, exp_perf);
    end
    clr();
    #1;
    chk("load_use_selfclear", stall, 0);

    // ---- multi-cycle op, MC_LAT=8 ----
    pulse_reset();
    chk("mc_pre_perf", perf_stall_cnt, 0);
    ex_mc_start = 1;
    #1;
    chk("mc_T_stall", stall, 1);
    chk("mc_T_busy", mc_busy, 0);
    tick();
    ex_mc_start = 0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      chk($sformatf("mc_T+%0d_stall", k), stall, 1);
      chk($sformatf("mc_T+%0d_busy", k), mc_busy, 1);
      chk($sformatf("mc_T+%0d_done", k), mc_done, 0);
      tick();
    end
    #1;
    chk("mc_T+8_stall", stall, 0);
    chk("mc_T+8_done", mc_done, 1);
    chk("mc_T+8_busy", mc_busy, 0);
    chk("mc_T+8_perf", perf_stall_cnt, 8);
    // A load-use hazard in DONE still stalls.
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    #1;
    chk("mc_done_loaduse_stall", stall, 1);
    tick();
    clr();
    #1;
    chk("mc_T+9_done", mc_done, 0);
    chk("mc_T+9_stall", stall, 0);
    chk("mc_T+9_perf", perf_stall_cnt, 9);
    chk("mc_no_overrun", mc_overrun, 0);

    // ---- overrun + reset mid-BUSY ----
    pulse_reset();
    ex_mc_start = 1;
    tick();                   // T -> T+1
    ex_mc_start = 0;
    tick();                   // T+2
    tick();                   // T+3
    ex_mc_start = 1;
    #1;
    chk("ovr_T+3_stall", stall, 1);
    chk("ovr_T+3_flag_pre", mc_overrun, 0);
    tick();                   // T+4
    ex_mc_start = 0;
    #1;
    chk("ovr_T+4_flag", mc_overrun, 1);
    chk("ovr_T+4_busy", mc_busy, 1);
    chk("ovr_T+4_stall", stall, 1);
    tick();                   // T+5
    chk("ovr_T+5_flag_sticky", mc_overrun, 1);
    rst_n = 1'b0;
    #1;
    chk("ovr_rst_stall", stall, 0);
    chk("ovr_rst_busy", mc_busy, 0);
    chk("ovr_rst_flag", mc_overrun, 0);
    chk("ovr_rst_perf", perf_stall_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("ovr_after_busy", mc_busy, 0);
    chk("ovr_after_stall", stall, 0);

    // ---- saturation ----
    pulse_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 12; id_rs1 = 12; id_use_rs1 = 1;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_perf4", s_perf, 15);
    chk("sat_perf16", perf_stall_cnt, 20);
    chk("sat_stall4", s_stall, 1);
    clr();
    tick();
    chk("sat_perf4_hold", s_perf, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decides each cycle whether the instruction in ID must be held, and drives the `stall` line into the ID-stage bubble mux.
- When `stall`=1, the bubble mux zeroes the ex/mem/wb control bundles entering ID/EX.
- Detects integer/FP load-use hazards combinationally.
- Sequences a fixed-latency structural stall for multi-cycle FP ops (fdiv/fsqrt) occupying EX.
- Keeps a saturating stall-cycle counter for power/performance profiling.

Parameters:
- MC_LAT, 8, total stall cycles for one multi-cycle FP op; legal range 2..31.
- CNT_W, 5, multi-cycle down-counter width; must satisfy 2^CNT_W > MC_LAT.
- PERF_W, 16, width of the stall-cycle profiling counter.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- id_rs1  input  5  ID source register 1 index
- id_rs2  input  5  ID source register 2 index
- id_rs3  input  5  ID source register 3 index (FMA)
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_use_rs3  input  1  ID instruction reads rs3
- id_rs1_fp  input  1  rs1 is an FP register
- id_rs2_fp  input  1  rs2 is an FP register
- id_rs3_fp  input  1  rs3 is an FP register
- ex_rd  input  5  EX destination index
- ex_rd_fp  input  1  EX destination is an FP register
- ex_mem_read  input  1  EX instruction is a load (lw/flw)
- ex_reg_write  input  1  EX instruction writes rd
- ex_mc_start  input  1  multi-cycle FP op entered EX this cycle (1-cycle pulse)
- flush  input  1  ID instruction is being squashed (taken branch/jump)
- stall  output  1  hold PC/IF-ID and insert a bubble into ID/EX
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- mc_busy  output  1  multi-cycle FSM in BUSY
- mc_done  output  1  registered 1-cycle pulse when the multi-cycle op completes
- mc_overrun  output  1  sticky error: ex_mc_start seen while not IDLE
- perf_stall_cnt  output  PERF_W  saturating count of cycles with stall=1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, mc_done=0, mc_overrun=0, perf_stall_cnt=0.
  - With all inputs 0: stall=0, pc_write=1, if_id_write=1.
- Source match, per rsN:
  - Matches when id_use_rsN && id_rsN==ex_rd && id_rsN_fp==ex_rd_fp.
  - An integer x0 source never matches. FP f0 does match.
- load_use = ex_mem_read && ex_reg_write && (any rsN match). Combinational, same-cycle. Self-clears next cycle because the bubble leaves EX with ex_mem_read=0.
- Multi-cycle FSM states: IDLE, BUSY, DONE.
  - IDLE: on ex_mc_start, go to BUSY with cnt<=MC_LAT-1.
  - BUSY: if cnt==1, go to DONE; otherwise cnt<=cnt-1.
  - DONE: go to IDLE unconditionally.
- mc_stall = (state==IDLE && ex_mc_start) || state==BUSY. Total mc stall cycles = MC_LAT exactly (start cycle + MC_LAT-1 BUSY cycles).
- mc_done = 1 only while state==DONE. stall is 0 in DONE unless load_use=1.
- stall = (load_use && !flush) || mc_stall.
  - flush masks load_use only; it never affects the FSM (an op in EX is older than the branch).
- pc_write = if_id_write = !stall.
- mc_busy = (state==BUSY).
- ex_mc_start while state!=IDLE: ignored by the FSM; mc_overrun<=1 and holds until reset.
- ex_mc_start in DONE is likewise an overrun. Back-to-back ops require one IDLE cycle.
- Simultaneous load_use and mc_stall: stall=1 (OR); no extra cycles are added.
- perf_stall_cnt increments each clock with stall=1 and saturates at all-ones.
- Reset asserted mid-BUSY: FSM returns to IDLE immediately and stall drops in the same cycle. Counts and flags clear.

Test Plan:
- Reset check: rst_n=0, then release with inputs 0 -> stall=0, pc_write=1, mc_busy=0, perf_stall_cnt=0.
- Integer load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> stall=1 one cycle, if_id_write=0. Repeat with ex_rd=0, id_rs2=0 -> stall=0. Repeat with id_rs2_fp=1 -> stall=0. Repeat both fp with index 0 -> stall=1.
- Flush masking: same load-use hazard with flush=1 -> stall=0, perf_stall_cnt unchanged.
- Multi-cycle, MC_LAT=8:
  - ex_mc_start pulse at cycle T -> stall=1 for cycles T..T+7 (8 cycles).
  - mc_busy=1 for T+1..T+7.
  - mc_done=1 at T+8 only, stall=0 at T+8.
  - perf_stall_cnt=8.
- Overrun: second ex_mc_start at T+3 -> no timing change, mc_overrun=1 sticky. rst_n pulse at T+5 -> stall=0, mc_busy=0, mc_overrun=0 immediately.
- Saturation: PERF_W=4, hold a load-use hazard 20 cycles -> perf_stall_cnt stops at 15.
